spi_ctrl_initiator: RTL and testbench
=====================================

Name: spi_ctrl_initiator

Overview:
SPI mode-0 controller (initiator) that generates 16-bit write frames for the onboarding SPI peripheral register map. Each frame is: R/W bit (1 = write), 7-bit address, 8-bit data, sent MSB first. The block drives the peripheral from the controller side, either in a test harness or on an on-chip loopback path. A valid/ready request port accepts one frame at a time, and a done pulse marks frame completion.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request; high only in IDLE
req_write  input  1  frame R/W bit; forced to 1 unless SPI_CTRL_READBACK_EN is defined
req_addr  input  7  register address
req_data  input  8  write data
busy  output  1  frame in progress; high whenever state is not IDLE
done  output  1  one-cycle pulse at frame completion
rd_data  output  8  captured read data; tied to 0 without the macro
sclk  output  1  SPI clock; idles low
copi  output  1  controller-out data
ncs  output  1  active-low chip select
cipo  input  1  controller-in data; unused without the macro

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, sclk=0, copi=0, ncs=1, req_ready=1, busy=0, done=0, rd_data=0.
- Accept rule: a request is taken on the cycle where req_valid && req_ready.
  - On that cycle, frame = {req_write, req_addr, req_data} is latched into a 16-bit shift register.
  - req_valid while busy is ignored; there is no queueing.
- Half-period counter: counts 0..CLK_DIV-1; a tick occurs when it reaches CLK_DIV-1.
- State machine:
  - IDLE: on accept -> SETUP.
  - SETUP: ncs=0, copi=frame[15], sclk=0, for CLK_DIV cycles -> SHIFT.
  - SHIFT: 16 bits; each bit is a low phase (CLK_DIV cycles) followed by a high phase (CLK_DIV cycles).
    - sclk rises at the start of the high phase.
    - On each falling edge, copi advances to the next bit. The first bit is already set up from SETUP.
    - After the 16th high phase, sclk falls -> HOLD.
  - HOLD: ncs=0, sclk=0, copi=0, for CLK_DIV cycles -> GAP.
  - GAP: ncs=1 for CLK_DIV cycles (minimum deselect time) -> IDLE.
  - done=1 on the first IDLE cycle after GAP, coincident with req_ready=1.
- Latency: ncs is low for CLK_DIV*34 cycles (136 at default). Accept to done is CLK_DIV*35+1 cycles.
- Bit counter: 4 bits, counts 15 down to 0. No wrap: SHIFT exits when the count reaches 0 at the end of a high phase.
- Back-to-back requests: a request accepted on the done cycle starts SETUP on the next cycle.
- Reset mid-frame: on the next edge all outputs return to their reset values and ncs=1 immediately. No done pulse is produced and the partial frame is discarded.
- sclk, copi and ncs are driven straight from registers, so there are no combinational glitches.

Optional Feature:
SPI_CTRL_READBACK_EN
- Defined:
  - req_write is honoured.
  - cipo is sampled on each sclk rising edge during bits 7..0 and shifted into a capture register MSB first.
  - rd_data is updated with the captured byte on the done cycle, for reads and writes alike.
  - rd_data holds its value until the next done.
- Undefined:
  - R/W bit is always 1.
  - cipo is ignored.
  - rd_data is constant 0.
  - No capture flops are synthesised.

Decomposition:
- Package spi_ctrl_pkg:
  - state enum: IDLE, SETUP, SHIFT, HOLD, GAP.
  - constants: FRAME_BITS=16, ADDR_W=7, DATA_W=8, RW_WRITE=1'b1.
- Sub-module spi_ctrl_tick: parameterised half-period divider with a clear input and a tick output.
  - Cleared on accept and on each state change.
  - The main FSM consumes its tick.

Test Plan:
- Reset: hold rst 3 cycles -> ncs=1, sclk=0, copi=0, req_ready=1, busy=0, done=0.
- Write addr=0x00 data=0xFF, CLK_DIV=4 -> 16 bits sampled on sclk rising edges equal 0x80FF; ncs low for exactly 136 cycles; exactly one done pulse, 141 cycles after accept.
- Write addr=0x04 data=0x5A -> bits 0x845A; copi stable for at least 4 cycles either side of each rising edge; a peripheral model's register 0x04 = 0x5A.
- Busy handling: req_valid held high throughout -> second frame accepted on the done cycle; ncs high for exactly 5 cycles between frames.
- Reset mid-frame: assert rst at bit 9 -> ncs=1 next cycle; no done pulse; a following request produces a clean full frame.
- Readback (macro defined): req_write=0, addr=0x02, cipo model drives 0xA5 on bits 7..0 -> frame bits 0x02xx; rd_data=0xA5 on the done cycle.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared widths, frame layout helper and FSM state encodings for the SPI write-frame initiator.
package spi_ctrl_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_ctrl_tick.sv
// SCLK half-period divider: tick pulses on the last of every CLK_DIV cycles; clr restarts the count.
// Latency: tick is a pure decode of the counter register, so clearing takes effect on the next cycle.
module spi_ctrl_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_ctrl_initiator.sv
// SPI mode-0 initiator sending {rw, addr[6:0], data[7:0]} MSB first; one frame at a time, req_ready only in IDLE.
// Accept to done is 35*CLK_DIV+1 cycles. Build with SPI_CTRL_READBACK_EN to honour req_write and capture cipo.
module spi_ctrl_initiator
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              sclk,
  output logic              copi,
  output logic              ncs,
  input  logic              cipo
);

  logic [2:0]            state_q, state_d;
  logic                  sclk_q, sclk_d;
  logic                  copi_q, copi_d;
  logic                  ncs_q, ncs_d;
  logic                  done_q, done_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  tick;
  logic                  tick_clr;
  logic                  accept;
  logic                  rw_bit;
  logic [FRAME_BITS-1:0] frame;

`ifdef SPI_CTRL_READBACK_EN
  assign rw_bit = req_write;
`else
  assign rw_bit = RW_WRITE;
`endif

  assign frame     = pack_frame(rw_bit, req_addr, req_data);
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    ncs_d     = ncs_q;
    done_d    = 1'b0;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SETUP;
          shreg_d   = frame;
          copi_d    = frame[FRAME_BITS-1];
          ncs_d     = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = 4'd15;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: present the next bit, or leave once bit 0 has been clocked.
            sclk_d = 1'b0;
            if (bit_cnt_q == 4'd0) begin
              state_d = ST_HOLD;
              copi_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q - 4'd1;
              shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
              copi_d    = shreg_q[FRAME_BITS-2];
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          ncs_d   = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick_clr = accept || (state_d != state_q);

  spi_ctrl_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      ncs_q     <= 1'b1;
      done_q    <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      ncs_q     <= ncs_d;
      done_q    <= done_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  // cipo is taken on the cycle sclk is driven high, during the eight data bits only.
  always_comb begin
    cap_d = cap_q;
    rd_d  = rd_q;
    if (accept) cap_d = '0;
    else if (state_q == ST_SHIFT && tick && !sclk_q && bit_cnt_q <= 4'd7)
      cap_d = {cap_q[DATA_W-2:0], cipo};
    if (state_q == ST_GAP && tick) rd_d = cap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
      rd_q  <= '0;
    end else begin
      cap_q <= cap_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;
`else
  logic unused_in;
  assign unused_in = ^{cipo, req_write};
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_spi_ctrl_initiator.sv
// Directed bench for spi_ctrl_initiator at CLK_DIV=4: frame vectors from a table plus back-to-back and mid-frame reset sequences.
module tb_spi_ctrl_initiator;

`ifdef SPI_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic        write;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [7:0]  cipo_byte;
    logic [15:0] exp_frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;

  int vec_cnt = 0;
  int miscnt  = 0;
  logic [7:0] periph_regs [128];
  vec_t vecs [4];

  always #5 clk = ~clk;

  spi_ctrl_initiator #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs),
    .cipo      (cipo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One frame from accept to a few cycles past done, sampling on the falling clk edge.
  task automatic run_frame(input vec_t v);
    int rises = 0, ncs_low = 0, done_cnt = 0, done_at = -1, viol = 0;
    int last_rise = -100, last_chg = -100;
    logic [15:0] bits = '0;
    logic [7:0]  rd_at_done = 8'hEE;
    logic prev_sclk, prev_copi;
    @(negedge clk);
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_data = v.data; cipo = 1'b0;
    prev_sclk = sclk; prev_copi = copi;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
      end
      if (!ncs) ncs_low++;
      if (copi !== prev_copi) begin
        if (k - last_rise < 4) viol++;
        last_chg = k;
      end
      if (sclk && !prev_sclk) begin
        if (k - last_chg < 4) viol++;
        bits = {bits[14:0], copi};
        rises++;
        last_rise = k;
      end
      if (done) begin
        done_cnt++;
        done_at = k;
        rd_at_done = rd_data;
      end
      prev_sclk = sclk; prev_copi = copi;
      cipo = (rises >= 8 && rises < 16) ? v.cipo_byte[3'(15 - rises)] : 1'b0;
    end
    if (bits[15]) periph_regs[bits[14:8]] = bits[7:0];
    chk("frame_bits", bits, v.exp_frame);
    chk("rise_count", rises, 16);
    chk("ncs_low_cycles", ncs_low, 136);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_at, 141);
    chk("copi_stability_violations", viol, 0);
    chk("rd_data_at_done", rd_at_done, RB ? v.cipo_byte : 8'h00);
    if (v.write) chk("periph_reg", periph_regs[v.addr], v.data);
  endtask

  initial begin
    int rises, done_cnt, hi_run, falls, gap, ncs_hi;
    logic prev_sclk, prev_ncs, reached;
    logic [15:0] b1, b2;
    vec_t rbv;

    vecs[0] = '{1'b1, 7'h00, 8'hFF, 8'h00, 16'h80FF};
    vecs[1] = '{1'b1, 7'h04, 8'h5A, 8'h3C, 16'h845A};
    vecs[2] = '{1'b1, 7'h7F, 8'h81, 8'hC3, 16'hFF81};
    vecs[3] = '{1'b1, 7'h2A, 8'h00, 8'h5A, 16'hAA00};
    for (int i = 0; i < 128; i++) periph_regs[i] = 8'h00;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b1; req_addr = '0; req_data = '0; cipo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_copi", copi, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Back-to-back: req_valid held high, second frame taken on the done cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h11; req_data = 8'h22;
    rises = 0; done_cnt = 0; hi_run = 0; falls = 0; gap = -1;
    b1 = '0; b2 = '0; prev_sclk = sclk; prev_ncs = ncs;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("b2b_ready_on_done", req_ready, 1);
          req_addr = 7'h33; req_data = 8'h44;
        end
      end else if (done_cnt == 1 && req_valid) begin
        req_valid = 1'b0;
      end
      if (ncs) hi_run++;
      else begin
        if (prev_ncs) begin
          if (falls == 1) gap = hi_run;
          falls++;
        end
        hi_run = 0;
      end
      if (sclk && !prev_sclk) begin
        if (falls == 1) b1 = {b1[14:0], copi};
        else            b2 = {b2[14:0], copi};
      end
      prev_sclk = sclk; prev_ncs = ncs;
    end
    req_valid = 1'b0;
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_ncs_gap", gap, 5);
    chk("b2b_frame1", b1, 16'h9122);
    chk("b2b_frame2", b2, 16'hB344);

    // Reset asserted once bit 9 is on the wire.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h55; req_data = 8'h66;
    rises = 0; reached = 1'b0; prev_sclk = sclk;
    for (int k = 1; k <= 100 && !reached; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rises == 7) reached = 1'b1;
    end
    chk("rst_mid_reached_bit9", reached, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ncs", ncs, 1);
    chk("rst_mid_sclk", sclk, 0);
    chk("rst_mid_copi", copi, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rd_data", rd_data, 0);
    done_cnt = 0; ncs_hi = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (ncs) ncs_hi++;
    end
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_ncs_stays_high", ncs_hi, 200);
    run_frame(vecs[1]);

    if (RB) begin
      rbv = '{1'b0, 7'h02, 8'h3C, 8'hA5, 16'h023C};
      run_frame(rbv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscnt);
    $finish;
  end

endmodule
